// File: rtl/scdatamem_responder.sv
// ----------------------------------------------------------------------------
// scdatamem_responder: data-port memory responder with programmable latency
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module scdatamem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Counter preload; a zero-wait build never enters the wait state.
  localparam logic [7:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 8'd0 : 8'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [7:0]            wait_cnt;
  logic                  lat_we;
  logic [31:0]           lat_addr;
  logic [31:0]           lat_wdata;
  logic [3:0]            lat_be;
  logic [31:0]           mem [DEPTH];

  logic                  accept;
  logic                  addr_err;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] word_idx;

  assign word_idx = lat_addr[ADDR_WIDTH+1:2];
  assign addr_err = (|lat_addr[1:0]) | (|lat_addr[31:ADDR_WIDTH+2]);
  assign accept   = (state == S_IDLE) & req_valid & ~reset;
  // Reset on the access edge must suppress the write.
  assign wr_en    = (state == S_ACCESS) & ~reset & lat_we & ~addr_err;

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = ~reset;
        if (req_valid) begin
          next_state = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt == 8'd0) begin
          next_state = S_ACCESS;
        end
      end
      S_ACCESS: begin
        next_state = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= 8'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        wait_cnt <= WAIT_INIT;
      end else if ((state == S_WAIT) && (wait_cnt != 8'd0)) begin
        wait_cnt <= wait_cnt - 8'd1;
      end
      if (state == S_ACCESS) begin
        rsp_err   <= addr_err;
        rsp_rdata <= (!addr_err && !lat_we) ? mem[word_idx] : 32'd0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  // RAM has no reset so its contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) begin
          mem[word_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_scdatamem_responder.sv
// ----------------------------------------------------------------------------
// tb_scdatamem_responder: directed self-checking bench for scdatamem_responder
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_scdatamem_responder;

  localparam int WA = 2;
  localparam int WB = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_req_valid = 0, a_req_we = 0, a_rsp_ready = 0;
  logic [31:0] a_req_addr = 0, a_req_wdata = 0;
  logic [3:0]  a_req_be = 0;
  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;

  logic        b_req_valid = 0, b_req_we = 0, b_rsp_ready = 0;
  logic [31:0] b_req_addr = 0, b_req_wdata = 0;
  logic [3:0]  b_req_be = 0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  int checks = 0;
  int failures = 0;

  scdatamem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WA)) dut_a (
    .clock(clk), .reset(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  scdatamem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WB)) dut_b (
    .clock(clk), .reset(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  // One full transaction on instance A (sel=0) or B (sel=1); called at a negedge.
  // lat counts cycles from the accept cycle to the first rsp_valid cycle, -1 on timeout.
  task automatic xact(input bit sel, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    if (sel) begin
      b_req_valid = 1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata; b_req_be = be;
    end else begin
      a_req_valid = 1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be;
    end
    guard = 0;
    while (!(sel ? b_req_ready : a_req_ready) && guard < 20) begin
      @(negedge clk); guard++;
    end
    @(posedge clk);
    @(negedge clk);
    if (sel) b_req_valid = 0; else a_req_valid = 0;
    lat = 1;
    while (!(sel ? b_rsp_valid : a_rsp_valid) && lat < 50) begin
      @(negedge clk); lat++;
    end
    if (!(sel ? b_rsp_valid : a_rsp_valid)) lat = -1;
    rdata = sel ? b_rsp_rdata : a_rsp_rdata;
    err   = sel ? b_rsp_err : a_rsp_err;
    if (sel) b_rsp_ready = 1; else a_rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    if (sel) b_rsp_ready = 0; else a_rsp_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_req_ready !== 1'b0) begin
      failures++; $display("FAIL reset_req_ready got=%b want=0", a_req_ready);
    end
    checks++;
    if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'd0 || a_rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b rdata=%h err=%b want 0/0/0",
               a_rsp_valid, a_rsp_rdata, a_rsp_err);
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if (a_req_ready !== 1'b1) begin
      failures++; $display("FAIL idle_req_ready got=%b want=1", a_req_ready);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    xact(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    checks++;
    if (lat !== WA + 2 || rd !== 32'd0 || er !== 1'b0) begin
      failures++; $display("FAIL store_rsp got lat=%0d rdata=%h err=%b want lat=%0d rdata=0 err=0",
                           lat, rd, er, WA + 2);
    end
    xact(0, 0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (lat !== WA + 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      failures++; $display("FAIL load_rsp got lat=%0d rdata=%h err=%b want lat=%0d rdata=deadbeef err=0",
                           lat, rd, er, WA + 2);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic er; int lat;
    xact(0, 1, 32'h40, 32'h11223344, 4'hF, rd, er, lat);
    xact(0, 1, 32'h40, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    xact(0, 0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h11BB33DD || er !== 1'b0) begin
      failures++; $display("FAIL byte_lane_merge got=%h err=%b want=11bb33dd err=0", rd, er);
    end
    xact(0, 1, 32'h40, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
    xact(0, 0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h11BB33DD) begin
      failures++; $display("FAIL be_zero_noop got=%h want=11bb33dd", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    xact(0, 0, 32'h13, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      failures++; $display("FAIL misaligned_load got err=%b rdata=%h want err=1 rdata=0", er, rd);
    end
    xact(0, 0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      failures++; $display("FAIL range_load got err=%b rdata=%h want err=1 rdata=0", er, rd);
    end
    // Both bad stores alias onto word 4 (0x10) if the error check is broken.
    xact(0, 1, 32'h11, 32'h0, 4'hF, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      failures++; $display("FAIL misaligned_store got err=%b rdata=%h want err=1 rdata=0", er, rd);
    end
    xact(0, 1, 32'h1010, 32'h0, 4'hF, rd, er, lat);
    xact(0, 0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      failures++; $display("FAIL err_ram_unchanged got=%h err=%b want=deadbeef err=0", rd, er);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; int guard; int bad;
    a_req_valid = 1; a_req_we = 0; a_req_addr = 32'h10; a_req_be = 4'h0;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 0;
    guard = 0;
    while (!a_rsp_valid && guard < 50) begin @(negedge clk); guard++; end
    checks++;
    if (a_rsp_valid !== 1'b1) begin
      failures++; $display("FAIL bp_rsp_arrives got valid=%b want=1", a_rsp_valid);
    end
    a_req_we = 1; a_req_wdata = 32'h0; a_req_be = 4'hF;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'hDEADBEEF || a_req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got valid=%b rdata=%h req_ready=%b want 1/deadbeef/0",
                 i, a_rsp_valid, a_rsp_rdata, a_req_ready);
      end
      a_req_valid = i[0] ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) failures++;
    a_req_valid = 0;
    a_rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    a_rsp_ready = 0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL bp_no_second_accept got %0d busy cycles want 0", bad);
    end
    xact(0, 0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL bp_ram_intact got=%h want=deadbeef", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; int guard;
    xact(0, 1, 32'h20, 32'h12345678, 4'hF, rd, er, lat);
    // Reset one cycle into WAIT.
    a_req_valid = 1; a_req_we = 1; a_req_addr = 32'h20; a_req_wdata = 32'h99999999; a_req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 0;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'd0 || a_rsp_err !== 1'b0 || a_req_ready !== 1'b0) begin
      failures++; $display("FAIL rst_wait_outputs got valid=%b rdata=%h err=%b ready=%b want 0/0/0/0",
                           a_rsp_valid, a_rsp_rdata, a_rsp_err, a_req_ready);
    end
    rst = 0;
    @(negedge clk);
    xact(0, 0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h12345678) begin
      failures++; $display("FAIL rst_wait_no_commit got=%h want=12345678", rd);
    end
    // Reset coinciding with the ACCESS edge.
    a_req_valid = 1; a_req_we = 1; a_req_addr = 32'h20; a_req_wdata = 32'h55555555; a_req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 0;
    repeat (WA) @(negedge clk);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    xact(0, 0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h12345678) begin
      failures++; $display("FAIL rst_access_no_write got=%h want=12345678", rd);
    end
    // Reset while the response is pending.
    a_req_valid = 1; a_req_we = 0; a_req_addr = 32'h20;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 0;
    guard = 0;
    while (!a_rsp_valid && guard < 50) begin @(negedge clk); guard++; end
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    checks++;
    if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'd0) begin
      failures++; $display("FAIL rst_resp_drop got valid=%b rdata=%h want 0/0", a_rsp_valid, a_rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] exp_data [4];
    int acc_cyc [4];
    int rsp_cyc [4];
    logic [31:0] got [4];
    int n_acc, n_rsp, cyc, bad;
    bit adv;
    exp_data[0] = 32'hA0A0A0A0; exp_data[1] = 32'hB1B1B1B1;
    exp_data[2] = 32'hC2C2C2C2; exp_data[3] = 32'hD3D3D3D3;
    for (int i = 0; i < 4; i++) xact(1, 1, 32'(i * 4), exp_data[i], 4'hF, rd, er, lat);
    xact(1, 0, 32'h8, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (lat !== WB + 2 || rd !== 32'hC2C2C2C2) begin
      failures++; $display("FAIL b2b_single got lat=%0d rdata=%h want lat=%0d rdata=c2c2c2c2",
                           lat, rd, WB + 2);
    end
    n_acc = 0; n_rsp = 0; adv = 0;
    b_rsp_ready = 1; b_req_we = 0; b_req_valid = 1; b_req_addr = 32'h0;
    for (cyc = 0; cyc < 40 && n_rsp < 4; cyc++) begin
      if (adv) begin
        adv = 0;
        if (n_acc < 4) b_req_addr = 32'(n_acc * 4); else b_req_valid = 0;
      end
      if (b_rsp_valid && n_rsp < 4) begin
        rsp_cyc[n_rsp] = cyc; got[n_rsp] = b_rsp_rdata; n_rsp++;
      end
      if (b_req_valid && b_req_ready && n_acc < 4) begin
        acc_cyc[n_acc] = cyc; n_acc++; adv = 1;
      end
      @(negedge clk);
    end
    b_req_valid = 0; b_rsp_ready = 0;
    checks++;
    if (n_rsp != 4) begin
      failures++; $display("FAIL b2b_count got=%0d want=4", n_rsp);
    end else begin
      bad = 0;
      for (int i = 0; i < 4; i++) begin
        if (got[i] !== exp_data[i] || rsp_cyc[i] - acc_cyc[i] != WB + 2) bad++;
        if (i > 0 && rsp_cyc[i] - rsp_cyc[i-1] != WB + 3) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL b2b_order_rate got d0=%h d3=%h gap=%0d want d0=a0a0a0a0 d3=d3d3d3d3 gap=%0d",
                 got[0], got[3], rsp_cyc[1] - rsp_cyc[0], WB + 3);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
